sram_rd_cache: RTL and testbench
================================

Name: sram_rd_cache

Overview:
- Direct-mapped, write-through, no-write-allocate word cache between the RISC5 CPU data/instruction port and the SRAM controller.
- Runs on the CPU clock. CPU-side port uses the controller's en/be/we/addr/data convention; the memory-side port drives the SRAM controller directly.
- Purpose: cut read latency on hits and keep SRAM bandwidth free for other masters.

Parameters:
- ADDR_W, 21: byte-address width. Word index field is addr[ADDR_W-1:2].
- IDX_W, 8: index bits; LINES = 2**IDX_W one-word lines. Tag width = ADDR_W-2-IDX_W (default 11).
- MEM_LAT, 1: number of clk cycles the SRAM controller needs per access (1..4).
- CNT_W, 16: width of the hit and miss counters.

Ports:
- clk  in  1  CPU clock
- rst  in  1  synchronous reset, active-high
- flush  in  1  one-cycle pulse; invalidates all lines
- cpu_en  in  1  request; en/be/we/addr/wdata held stable until cpu_rdy
- cpu_be  in  1  byte access; lane = cpu_addr[1:0]
- cpu_we  in  1  write
- cpu_addr  in  ADDR_W  byte address
- cpu_wdata  in  32  write data; the byte is replicated across all lanes on byte writes
- cpu_rdata  out  32  full read word; the CPU selects the lane
- cpu_rdy  out  1  one-cycle completion strobe
- mem_en  out  1  SRAM request, held for exactly MEM_LAT cycles
- mem_be, mem_we  out  1 each  passed through from the CPU request
- mem_addr  out  ADDR_W  passed through
- mem_wdata  out  32  passed through
- mem_rdata  in  32  sampled on the clk edge ending the last mem_en cycle
- hit_cnt, miss_cnt  out  CNT_W each  saturating counters; reads only

Behaviour:
- Storage
  - Synchronous tag+data RAM (one-cycle read).
  - Valid bits held in flops.
- Reset
  - Reset state: IDLE, all valid bits 0, mem_en=0, cpu_rdy=0, cpu_rdata=0, counters 0, pending flush cleared.
  - Reset asserted mid-operation aborts immediately: mem_en falls in the next cycle and no cpu_rdy is issued.
- FSM states: IDLE, LOOKUP, FILL, WRITE, DONE, FLUSH.
- IDLE
  - Pending flush (or flush this cycle) has priority: go to FLUSH, clear all valid bits in one cycle, return to IDLE.
  - Otherwise, if cpu_en: issue the RAM read at the index, register the request, go to LOOKUP.
- LOOKUP
  - Hit = valid && tag match.
  - Read hit: cpu_rdy=1 this cycle, cpu_rdata=RAM word, hit_cnt++, go to IDLE. Total latency: rdy in cycle 1 after acceptance.
  - Read miss: miss_cnt++, go to FILL.
  - Write (hit or miss): go to WRITE.
- FILL
  - mem_en=1, mem_we=0 for MEM_LAT cycles.
  - On the final edge: write mem_rdata and the tag into the line, set valid, latch cpu_rdata; go to DONE.
- WRITE
  - mem_en=1, mem_we=1 for MEM_LAT cycles.
  - On the final edge, if the request was a hit: word write updates the whole line; byte write updates only lane addr[1:0] (bits 8*lane+7:8*lane).
  - On a miss the line is untouched and the write is not counted.
  - Go to DONE.
- DONE: cpu_rdy=1 for one cycle, go to IDLE. Miss and write latency = 2+MEM_LAT cycles to rdy.
- Timing rules
  - A new request is accepted no earlier than the cycle after cpu_rdy.
  - cpu_en still high in that cycle counts as a new request.
- flush while not IDLE: latched as pending and executed at the next IDLE, before any new request.
- Counters saturate at all-ones and never wrap.
- Byte reads are treated as word reads: same hit/miss rules.

Decomposition:
- Package sram_cache_pkg holds:
  - state encoding;
  - derived widths TAG_W and LINES;
  - functions idx_of(addr), tag_of(addr) and byte_merge(old, new, lane).
- One sub-module, cache_line_ram: synchronous single-port RAM, TAG_W+32 bits wide, with byte-lane write enables.

Test Plan:
- Reset, read 0x000100, memory returns 0xDEADBEEF → one mem_en cycle; cpu_rdy at cycle 3; cpu_rdata=0xDEADBEEF; miss_cnt=1.
- Re-read 0x000100 → cpu_rdy at cycle 1; no mem_en; data 0xDEADBEEF; hit_cnt=1.
- Byte write be=1, addr 0x000102, wdata 0x55555555 → mem_en with mem_we=1, mem_be=1, mem_addr=0x000102; then read 0x000100 hits with 0xDE55BEEF.
- Read 0x000500 (same index 0x40, different tag) → miss, line replaced; then read 0x000100 → miss again; miss_cnt increments both times.
- Write miss to 0x000200 → memory write issued, no allocate; following read of 0x000200 → miss with mem_en.
- flush pulse during a FILL → FILL completes, then FLUSH runs, then read 0x000100 misses. Separately, rst asserted in FILL → mem_en=0 and cpu_rdy=0 next cycle, counters 0.

Source files
------------

// File: rtl/sram_cache_pkg.sv
// Shared widths, FSM encoding and address/byte helpers for the SRAM read cache.
package sram_cache_pkg;

  localparam int ADDR_W = 21;
  localparam int IDX_W  = 8;
  localparam int TAG_W  = ADDR_W - 2 - IDX_W;
  localparam int LINES  = 1 << IDX_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_FILL,
    S_WRITE,
    S_DONE,
    S_FLUSH
  } state_e;

  function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_W-1:0] addr);
    return addr[IDX_W+1:2];
  endfunction

  function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1:IDX_W+2];
  endfunction

  // Replace one byte lane of a word, leaving the other three lanes intact.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [7:0]  new_byte,
                                             input logic [1:0]  lane);
    logic [31:0] w;
    w = old_word;
    w[8*lane +: 8] = new_byte;
    return w;
  endfunction

endpackage

// File: rtl/cache_line_ram.sv
// Single-port synchronous tag+data RAM; one-cycle read, per-lane and tag write enables.
module cache_line_ram #(
  parameter int AW = 8,
  parameter int TW = 11
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic          tag_we,
  input  logic [3:0]    lane_we,
  input  logic [AW-1:0] addr,
  input  logic [TW-1:0] wtag,
  input  logic [31:0]   wdata,
  output logic [TW-1:0] rtag,
  output logic [31:0]   rdata
);

  logic [TW+31:0] mem_q [2**AW];
  logic [TW+31:0] rd_q;

  // Read output only changes on a read, so it keeps the looked-up line during a write.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        if (tag_we) mem_q[addr][TW+31:32] <= wtag;
        for (int i = 0; i < 4; i++) begin
          if (lane_we[i]) mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rd_q <= mem_q[addr];
      end
    end
  end

  assign {rtag, rdata} = rd_q;

endmodule

// File: rtl/sram_rd_cache.sv
// Direct-mapped, write-through, no-write-allocate one-word-line cache in front of the
// SRAM controller; hits answer one cycle after acceptance.
module sram_rd_cache
  import sram_cache_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              cpu_en,
  input  logic              cpu_be,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_rdy,
  output logic              mem_en,
  output logic              mem_be,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  state_e            state_q, state_d;
  logic [LINES-1:0]  valid_q, valid_d;
  logic              flush_pend_q, flush_pend_d;
  logic              req_be_q, req_be_d;
  logic              req_we_q, req_we_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [31:0]       req_wdata_q, req_wdata_d;
  logic              hit_q, hit_d;
  logic [1:0]        lat_q, lat_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;

  logic              ram_en, ram_we, ram_tag_we;
  logic [3:0]        ram_lane_we;
  logic [IDX_W-1:0]  ram_addr;
  logic [TAG_W-1:0]  ram_wtag, ram_rtag;
  logic [31:0]       ram_wdata, ram_rdata;
  logic              lookup_hit, last_beat;

  cache_line_ram #(.AW(IDX_W), .TW(TAG_W)) u_ram (
    .clk     (clk),
    .en      (ram_en),
    .we      (ram_we),
    .tag_we  (ram_tag_we),
    .lane_we (ram_lane_we),
    .addr    (ram_addr),
    .wtag    (ram_wtag),
    .wdata   (ram_wdata),
    .rtag    (ram_rtag),
    .rdata   (ram_rdata)
  );

  assign mem_be    = req_be_q;
  assign mem_we    = req_we_q;
  assign mem_addr  = req_addr_q;
  assign mem_wdata = req_wdata_q;
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    flush_pend_d = flush_pend_q | flush;
    req_be_d     = req_be_q;
    req_we_d     = req_we_q;
    req_addr_d   = req_addr_q;
    req_wdata_d  = req_wdata_q;
    hit_d        = hit_q;
    lat_d        = lat_q;
    rdata_d      = rdata_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    cpu_rdy      = 1'b0;
    cpu_rdata    = rdata_q;
    mem_en       = 1'b0;
    ram_en       = 1'b0;
    ram_we       = 1'b0;
    ram_tag_we   = 1'b0;
    ram_lane_we  = 4'h0;
    ram_addr     = idx_of(req_addr_q);
    ram_wtag     = tag_of(req_addr_q);
    ram_wdata    = mem_rdata;
    lookup_hit   = valid_q[idx_of(req_addr_q)] && (ram_rtag == tag_of(req_addr_q));
    last_beat    = (lat_q == 2'(MEM_LAT - 1));

    case (state_q)
      S_IDLE: begin
        // A flush always runs before the next request is taken.
        if (flush_pend_q || flush) begin
          state_d = S_FLUSH;
        end else if (cpu_en) begin
          req_be_d    = cpu_be;
          req_we_d    = cpu_we;
          req_addr_d  = cpu_addr;
          req_wdata_d = cpu_wdata;
          ram_en      = 1'b1;
          ram_addr    = idx_of(cpu_addr);
          state_d     = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        hit_d = lookup_hit;
        lat_d = 2'd0;
        if (req_we_q) begin
          state_d = S_WRITE;
        end else if (lookup_hit) begin
          cpu_rdy   = 1'b1;
          cpu_rdata = ram_rdata;
          rdata_d   = ram_rdata;
          hit_cnt_d = (&hit_cnt_q) ? hit_cnt_q : hit_cnt_q + 1'b1;
          state_d   = S_IDLE;
        end else begin
          miss_cnt_d = (&miss_cnt_q) ? miss_cnt_q : miss_cnt_q + 1'b1;
          state_d    = S_FILL;
        end
      end
      S_FILL: begin
        mem_en = 1'b1;
        if (last_beat) begin
          ram_en                        = 1'b1;
          ram_we                        = 1'b1;
          ram_tag_we                    = 1'b1;
          ram_lane_we                   = 4'hF;
          valid_d[idx_of(req_addr_q)]   = 1'b1;
          rdata_d                       = mem_rdata;
          state_d                       = S_DONE;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      S_WRITE: begin
        mem_en = 1'b1;
        if (last_beat) begin
          // The RAM output still holds the line read at lookup, so a byte merge is safe.
          if (hit_q) begin
            ram_en      = 1'b1;
            ram_we      = 1'b1;
            ram_lane_we = req_be_q ? (4'h1 << req_addr_q[1:0]) : 4'hF;
            ram_wdata   = req_be_q ? byte_merge(ram_rdata, req_wdata_q[8*req_addr_q[1:0] +: 8],
                                                req_addr_q[1:0])
                                   : req_wdata_q;
          end
          state_d = S_DONE;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      S_DONE: begin
        cpu_rdy = 1'b1;
        state_d = S_IDLE;
      end
      S_FLUSH: begin
        valid_d      = '0;
        flush_pend_d = flush;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      valid_q      <= '0;
      flush_pend_q <= 1'b0;
      req_be_q     <= 1'b0;
      req_we_q     <= 1'b0;
      req_addr_q   <= '0;
      req_wdata_q  <= '0;
      hit_q        <= 1'b0;
      lat_q        <= 2'd0;
      rdata_q      <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      flush_pend_q <= flush_pend_d;
      req_be_q     <= req_be_d;
      req_we_q     <= req_we_d;
      req_addr_q   <= req_addr_d;
      req_wdata_q  <= req_wdata_d;
      hit_q        <= hit_d;
      lat_q        <= lat_d;
      rdata_q      <= rdata_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

endmodule

// File: tb/tb_sram_rd_cache.sv
// Directed bench for sram_rd_cache with MEM_LAT=1: latency, hit/miss, write-through,
// flush and reset behaviour, each expectation worked out by hand.
module tb_sram_rd_cache;

  logic        clk = 1'b0;
  logic        rst, flush, cpu_en, cpu_be, cpu_we;
  logic [20:0] cpu_addr;
  logic [31:0] cpu_wdata, cpu_rdata, mem_rdata, mem_wdata;
  logic        cpu_rdy, mem_en, mem_be, mem_we;
  logic [20:0] mem_addr;
  logic [15:0] hit_cnt, miss_cnt;

  int checks = 0;
  int errors = 0;

  int          rdy_cyc, mem_cyc;
  logic [31:0] rdata;
  logic        seen_we, seen_be;
  logic [20:0] seen_addr;
  logic [31:0] seen_wdata;

  sram_rd_cache #(.MEM_LAT(1), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .cpu_en    (cpu_en),
    .cpu_be    (cpu_be),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_rdy   (cpu_rdy),
    .mem_en    (mem_en),
    .mem_be    (mem_be),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation hung");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; cycle 0 is the acceptance cycle, rdy_cyc is -1 on timeout.
  task automatic do_req(input logic be, input logic we, input logic [20:0] addr,
                        input logic [31:0] wdata, input logic [31:0] mdata, input int flush_at);
    cpu_en = 1'b1; cpu_be = be; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    mem_rdata = mdata; flush = (flush_at == 0);
    rdy_cyc = -1; mem_cyc = 0; rdata = 'x;
    seen_we = 1'bx; seen_be = 1'bx; seen_addr = 'x; seen_wdata = 'x;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); @(negedge clk);
      flush = (c == flush_at);
      if (mem_en) begin
        mem_cyc++;
        seen_we = mem_we; seen_be = mem_be; seen_addr = mem_addr; seen_wdata = mem_wdata;
      end
      if (cpu_rdy) begin
        rdy_cyc = c;
        rdata   = cpu_rdata;
        break;
      end
    end
    cpu_en = 1'b0; flush = 1'b0;
    @(posedge clk); @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; cpu_en = 1'b0; cpu_be = 1'b0; cpu_we = 1'b0;
    cpu_addr = '0; cpu_wdata = '0; mem_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_rdy",   32'(cpu_rdy),  32'd0);
    check("reset_memen", 32'(mem_en),   32'd0);
    check("reset_rdata", cpu_rdata,     32'd0);
    check("reset_hit",   32'(hit_cnt),  32'd0);
    check("reset_miss",  32'(miss_cnt), 32'd0);

    // Cold read miss
    do_req(1'b0, 1'b0, 21'h000100, 32'h0, 32'hDEADBEEF, -1);
    check("miss1_lat",   32'(rdy_cyc),  32'd3);
    check("miss1_memen", 32'(mem_cyc),  32'd1);
    check("miss1_memwe", 32'(seen_we),  32'd0);
    check("miss1_data",  rdata,         32'hDEADBEEF);
    check("miss1_cnt",   32'(miss_cnt), 32'd1);

    // Read hit
    do_req(1'b0, 1'b0, 21'h000100, 32'h0, 32'h0, -1);
    check("hit1_lat",   32'(rdy_cyc), 32'd1);
    check("hit1_memen", 32'(mem_cyc), 32'd0);
    check("hit1_data",  rdata,        32'hDEADBEEF);
    check("hit1_cnt",   32'(hit_cnt), 32'd1);

    // Byte write hit to lane 2, then read back merged word
    do_req(1'b1, 1'b1, 21'h000102, 32'h55555555, 32'h0, -1);
    check("bw_lat",   32'(rdy_cyc),   32'd3);
    check("bw_memen", 32'(mem_cyc),   32'd1);
    check("bw_memwe", 32'(seen_we),   32'd1);
    check("bw_membe", 32'(seen_be),   32'd1);
    check("bw_addr",  32'(seen_addr), 32'h000102);
    check("bw_wdata", seen_wdata,     32'h55555555);
    check("bw_hit",   32'(hit_cnt),   32'd1);
    check("bw_miss",  32'(miss_cnt),  32'd1);
    do_req(1'b0, 1'b0, 21'h000100, 32'h0, 32'h0, -1);
    check("bwrd_lat",  32'(rdy_cyc), 32'd1);
    check("bwrd_data", rdata,        32'hDE55BEEF);
    check("bwrd_hit",  32'(hit_cnt), 32'd2);

    // Conflict on index 0x40: replace line, then original address misses again
    do_req(1'b0, 1'b0, 21'h000500, 32'h0, 32'h12345678, -1);
    check("conf1_lat",  32'(rdy_cyc),  32'd3);
    check("conf1_data", rdata,         32'h12345678);
    check("conf1_miss", 32'(miss_cnt), 32'd2);
    do_req(1'b0, 1'b0, 21'h000100, 32'h0, 32'hDE55BEEF, -1);
    check("conf2_lat",  32'(rdy_cyc),  32'd3);
    check("conf2_data", rdata,         32'hDE55BEEF);
    check("conf2_miss", 32'(miss_cnt), 32'd3);

    // Word write hit updates the whole line
    do_req(1'b0, 1'b1, 21'h000100, 32'h0BADF00D, 32'h0, -1);
    check("ww_lat", 32'(rdy_cyc), 32'd3);
    do_req(1'b0, 1'b0, 21'h000100, 32'h0, 32'h0, -1);
    check("wwrd_lat",  32'(rdy_cyc), 32'd1);
    check("wwrd_data", rdata,        32'h0BADF00D);
    check("wwrd_hit",  32'(hit_cnt), 32'd3);

    // Write miss: no allocation, later read still goes to memory
    do_req(1'b0, 1'b1, 21'h000200, 32'hCAFEF00D, 32'h0, -1);
    check("wm_lat",   32'(rdy_cyc),  32'd3);
    check("wm_memwe", 32'(seen_we),  32'd1);
    check("wm_miss",  32'(miss_cnt), 32'd3);
    check("wm_hit",   32'(hit_cnt),  32'd3);
    do_req(1'b0, 1'b0, 21'h000200, 32'h0, 32'hCAFEF00D, -1);
    check("wmrd_lat",   32'(rdy_cyc),  32'd3);
    check("wmrd_memen", 32'(mem_cyc),  32'd1);
    check("wmrd_miss",  32'(miss_cnt), 32'd4);

    // Flush pulse during FILL: fill completes, then the pending flush invalidates
    do_req(1'b0, 1'b0, 21'h000300, 32'h0, 32'h11112222, 2);
    check("fl_lat",  32'(rdy_cyc), 32'd3);
    check("fl_data", rdata,        32'h11112222);
    repeat (3) @(negedge clk);
    do_req(1'b0, 1'b0, 21'h000100, 32'h0, 32'h0BADF00D, -1);
    check("flrd_lat",  32'(rdy_cyc),  32'd3);
    check("flrd_miss", 32'(miss_cnt), 32'd6);

    // Reset during FILL aborts the access
    cpu_en = 1'b1; cpu_be = 1'b0; cpu_we = 1'b0; cpu_addr = 21'h000600; mem_rdata = 32'h0;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    check("rstf_memen_before", 32'(mem_en), 32'd1);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check("rstf_memen", 32'(mem_en),   32'd0);
    check("rstf_rdy",   32'(cpu_rdy),  32'd0);
    check("rstf_hit",   32'(hit_cnt),  32'd0);
    check("rstf_miss",  32'(miss_cnt), 32'd0);
    rst = 1'b0; cpu_en = 1'b0;
    @(negedge clk);
    do_req(1'b0, 1'b0, 21'h000100, 32'h0, 32'h0BADF00D, -1);
    check("rstrd_lat",  32'(rdy_cyc),  32'd3);
    check("rstrd_miss", 32'(miss_cnt), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
